ppe_rr_sched: RTL and testbench
===============================

PPE_RR_SCHED -- requirements
Module: ppe_rr_sched

Interface
REQ-001 Parameter WIDTH, default 1024: number of requesters; SHALL equal 2**LOG_W.
REQ-002 Parameter LOG_W, default 10: width of the pointer and grant index.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port req, input, WIDTH: level request vector, bit i = requester i.
REQ-006 Port ptr_ld, input, 1: one-cycle strobe to load the priority pointer.
REQ-007 Port ptr_val, input, LOG_W: pointer value loaded when ptr_ld=1.
REQ-008 Port gnt_rdy, input, 1: consumer accepts the presented grant.
REQ-009 Port gnt_vld, output, 1: a registered grant is presented.
REQ-010 Port gnt_onehot, output, WIDTH: registered one-hot grant vector.
REQ-011 Port gnt_idx, output, LOG_W: registered binary index of the granted bit.
REQ-012 Port ptr, output, LOG_W: current priority pointer.
REQ-013 Port busy, output, 1: high in state GRANT.

Function
REQ-014 The block SHALL instantiate ppe (Req=req, P_enc=ptr) to select the winner.
- Winner: lowest index i >= ptr with req[i]=1; if none, lowest i with req[i]=1.
REQ-015 The block SHALL convert the ppe one-hot winner to binary for gnt_idx; no priority tie-break beyond ppe.
REQ-016 FSM states: IDLE, GRANT; the reset state SHALL be IDLE.
REQ-017 IDLE with |req=1 -> GRANT next cycle; gnt_onehot/gnt_idx SHALL capture the winner; gnt_vld=1.
REQ-018 IDLE with req=0 -> stay in IDLE; gnt_vld=0; gnt_onehot=0.
REQ-019 In GRANT, gnt_vld, gnt_onehot and gnt_idx SHALL hold stable until gnt_vld&gnt_rdy, regardless of req changes, including deassertion of the granted bit.
REQ-020 Handshake (GRANT & gnt_rdy) -> IDLE next cycle; gnt_vld=0 and gnt_onehot=0 next cycle; ptr <= gnt_idx+1 modulo WIDTH (WIDTH-1 wraps to 0).
REQ-021 Latency: request in IDLE at cycle N -> gnt_vld=1 at N+1; after a handshake at cycle M, the earliest next gnt_vld=1 is M+2 (one mandatory IDLE bubble).
REQ-022 ptr_ld=1 SHALL set ptr <= ptr_val next cycle in any state.
REQ-023 ptr_ld and a handshake in the same cycle: ptr_ld SHALL win.
REQ-024 ptr_ld in GRANT SHALL NOT alter the presented grant; the new ptr applies from the next arbitration.
REQ-025 ptr_ld in IDLE coincident with a request: arbitration that cycle SHALL use the old ptr.
REQ-026 gnt_rdy in IDLE SHALL be ignored.
REQ-027 busy SHALL equal (state==GRANT); gnt_vld SHALL equal busy.

Reset
REQ-028 rst=1 SHALL asynchronously force state=IDLE, ptr=0, gnt_vld=0, gnt_onehot=0, gnt_idx=0, busy=0.
REQ-029 rst asserted mid-GRANT SHALL drop the grant immediately without a handshake and without advancing ptr.
REQ-030 First arbitration after rst deasserts SHALL use ptr=0.

Verification (WIDTH=8, LOG_W=3)
REQ-031 Reset, then req=8'b1000_0100 -> next cycle gnt_vld=1, gnt_idx=2, gnt_onehot=8'h04; gnt_rdy=1 -> ptr=3, then gnt_idx=7.
REQ-032 Wrap: ptr=7 via ptr_ld, req=8'b0100_0001 -> gnt_idx=0; handshake -> ptr=1.
REQ-033 Hold: grant idx 5 presented, gnt_rdy=0 for 4 cycles while req changes to 0 -> gnt_idx=5, gnt_vld=1 unchanged throughout.
REQ-034 Collision: in GRANT idx 2, ptr_ld=1, ptr_val=6 with gnt_rdy=1 -> ptr=6 (not 3), state IDLE.
REQ-035 Fairness: req=8'hFF held, gnt_rdy=1 always -> gnt_idx sequence 0,1,...,7,0 with gnt_vld high every other cycle.
REQ-036 Async reset: rst pulsed between clock edges during GRANT -> gnt_vld=0 before the next edge, ptr=0.

Source files
------------

// File: rtl/ppe_rr_sched.sv
// ppe_rr_sched: round-robin grant scheduler built on a programmable priority encoder.
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset
//   req        - WIDTH-bit level request vector
//   ptr_ld     - load strobe for the priority pointer
//   ptr_val    - pointer value taken when ptr_ld=1
//   gnt_rdy    - consumer accepts the presented grant
//   gnt_vld    - registered grant valid (equals busy)
//   gnt_onehot - registered one-hot grant
//   gnt_idx    - registered binary index of the grant
//   ptr        - current priority pointer
//   busy       - high while a grant is presented
module ppe #(
  parameter int WIDTH = 1024,
  parameter int LOG_W = 10
) (
  input  logic [WIDTH-1:0] Req,
  input  logic [LOG_W-1:0] P_enc,
  output logic [WIDTH-1:0] gnt
);
  logic [WIDTH-1:0] masked;
  logic [WIDTH-1:0] pick;
  always_comb begin
    masked = Req & ({WIDTH{1'b1}} << P_enc);
    pick   = (|masked) ? masked : Req;
    // x & -x isolates the lowest set bit
    gnt    = pick & (~pick + 1'b1);
  end
endmodule

module ppe_rr_sched #(
  parameter int WIDTH = 1024,
  parameter int LOG_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             ptr_ld,
  input  logic [LOG_W-1:0] ptr_val,
  input  logic             gnt_rdy,
  output logic             gnt_vld,
  output logic [WIDTH-1:0] gnt_onehot,
  output logic [LOG_W-1:0] gnt_idx,
  output logic [LOG_W-1:0] ptr,
  output logic             busy
);
  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;
  logic             state_q, state_d;
  logic [WIDTH-1:0] gnt_onehot_q, gnt_onehot_d;
  logic [LOG_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [LOG_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] win;
  logic [LOG_W-1:0] win_idx;
  logic             take, hs;
  ppe #(.WIDTH(WIDTH), .LOG_W(LOG_W)) u_ppe (
    .Req  (req),
    .P_enc(ptr_q),
    .gnt  (win)
  );
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (win[i]) win_idx = win_idx | LOG_W'(i);
  end
  always_comb begin
    take         = (state_q == IDLE) && (|req);
    hs           = (state_q == GRANT) && gnt_rdy;
    state_d      = take ? GRANT : hs ? IDLE : state_q;
    gnt_onehot_d = take ? win : hs ? '0 : gnt_onehot_q;
    gnt_idx_d    = take ? win_idx : gnt_idx_q;
    // a pointer load overrides the post-handshake advance; the add wraps modulo WIDTH
    ptr_d        = ptr_ld ? ptr_val : hs ? gnt_idx_q + 1'b1 : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_onehot_q <= '0;
      gnt_idx_q    <= '0;
      ptr_q        <= '0;
    end else begin
      state_q      <= state_d;
      gnt_onehot_q <= gnt_onehot_d;
      gnt_idx_q    <= gnt_idx_d;
      ptr_q        <= ptr_d;
    end
  end
  assign busy       = (state_q == GRANT);
  assign gnt_vld    = busy;
  assign gnt_onehot = gnt_onehot_q;
  assign gnt_idx    = gnt_idx_q;
  assign ptr        = ptr_q;
endmodule

// File: tb/tb_ppe_rr_sched.sv
// tb_ppe_rr_sched: directed and random checks of ppe_rr_sched against a round-robin reference model.
module tb_ppe_rr_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       ptr_ld = 1'b0;
  logic [2:0] ptr_val = '0;
  logic       gnt_rdy = 1'b0;
  logic       gnt_vld;
  logic [7:0] gnt_onehot;
  logic [2:0] gnt_idx;
  logic [2:0] ptr;
  logic       busy;
  int n_chk = 0;
  int n_err = 0;
  logic       m_vld = 1'b0;
  logic [2:0] m_idx = '0;
  logic [2:0] m_ptr = '0;
  ppe_rr_sched #(.WIDTH(8), .LOG_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ptr_ld    (ptr_ld),
    .ptr_val   (ptr_val),
    .gnt_rdy   (gnt_rdy),
    .gnt_vld   (gnt_vld),
    .gnt_onehot(gnt_onehot),
    .gnt_idx   (gnt_idx),
    .ptr       (ptr),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [2:0] winner(input logic [7:0] r, input logic [2:0] p);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (int'(p) + k) % 8;
      if (r[i]) return 3'(i);
    end
    return 3'd0;
  endfunction
  task automatic model_reset();
    m_vld = 1'b0;
    m_idx = '0;
    m_ptr = '0;
  endtask
  task automatic model_clk();
    logic [2:0] np;
    np = m_ptr;
    if (m_vld) begin
      if (gnt_rdy) begin
        m_vld = 1'b0;
        np = 3'(m_idx + 3'd1);
      end
    end else if (req != 0) begin
      m_vld = 1'b1;
      m_idx = winner(req, m_ptr);
    end
    if (ptr_ld) np = ptr_val;
    m_ptr = np;
  endtask
  task automatic check_all();
    chk("vld", 32'(gnt_vld), 32'(m_vld));
    chk("busy", 32'(busy), 32'(m_vld));
    chk("onehot", 32'(gnt_onehot), m_vld ? 32'(1) << m_idx : 32'd0);
    if (m_vld) chk("idx", 32'(gnt_idx), 32'(m_idx));
    chk("ptr", 32'(ptr), 32'(m_ptr));
  endtask
  task automatic step(input logic [7:0] r, input logic rd, input logic ld, input logic [2:0] pv);
    req = r;
    gnt_rdy = rd;
    ptr_ld = ld;
    ptr_val = pv;
    @(posedge clk);
    model_clk();
    @(negedge clk);
    check_all();
  endtask
  initial begin
    repeat (2) @(negedge clk);
    model_reset();
    check_all();
    rst = 1'b0;
    step(8'h84, 1'b0, 1'b0, 3'd0);
    chk("r31_vld", 32'(gnt_vld), 32'd1);
    chk("r31_idx", 32'(gnt_idx), 32'd2);
    chk("r31_oh", 32'(gnt_onehot), 32'h04);
    step(8'h84, 1'b1, 1'b0, 3'd0);
    chk("r31_ptr", 32'(ptr), 32'd3);
    step(8'h84, 1'b0, 1'b0, 3'd0);
    chk("r31_idx7", 32'(gnt_idx), 32'd7);
    step(8'h84, 1'b1, 1'b0, 3'd0);
    step(8'h00, 1'b0, 1'b1, 3'd7);
    step(8'h41, 1'b0, 1'b0, 3'd0);
    chk("r32_idx", 32'(gnt_idx), 32'd0);
    step(8'h41, 1'b1, 1'b0, 3'd0);
    chk("r32_ptr", 32'(ptr), 32'd1);
    step(8'h05, 1'b0, 1'b1, 3'd0);
    chk("r25_idx", 32'(gnt_idx), 32'd2);
    step(8'h00, 1'b1, 1'b0, 3'd0);
    step(8'h00, 1'b0, 1'b1, 3'd5);
    step(8'h20, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      step(8'h00, 1'b0, 1'b0, 3'd0);
      chk("r33_idx", 32'(gnt_idx), 32'd5);
      chk("r33_vld", 32'(gnt_vld), 32'd1);
    end
    step(8'h00, 1'b1, 1'b0, 3'd0);
    step(8'h00, 1'b0, 1'b1, 3'd2);
    step(8'h04, 1'b0, 1'b0, 3'd0);
    step(8'h04, 1'b0, 1'b1, 3'd4);
    chk("r24_idx", 32'(gnt_idx), 32'd2);
    step(8'h00, 1'b1, 1'b1, 3'd6);
    chk("r34_ptr", 32'(ptr), 32'd6);
    chk("r34_vld", 32'(gnt_vld), 32'd0);
    step(8'h00, 1'b1, 1'b0, 3'd0);
    chk("r26_ptr", 32'(ptr), 32'd6);
    step(8'h00, 1'b0, 1'b1, 3'd0);
    for (int k = 0; k < 18; k++) begin
      step(8'hFF, 1'b1, 1'b0, 3'd0);
      chk("r35_vld", 32'(gnt_vld), 32'(k % 2 == 0));
      if (k % 2 == 0) chk("r35_idx", 32'(gnt_idx), 32'((k / 2) % 8));
    end
    step(8'h00, 1'b1, 1'b0, 3'd0);
    step(8'h04, 1'b0, 1'b0, 3'd0);
    step(8'h08, 1'b1, 1'b0, 3'd0);
    step(8'h10, 1'b0, 1'b0, 3'd0);
    chk("r36_pre", 32'(gnt_vld), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("r36_vld", 32'(gnt_vld), 32'd0);
    chk("r36_ptr", 32'(ptr), 32'd0);
    chk("r36_oh", 32'(gnt_onehot), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    step(8'h81, 1'b0, 1'b0, 3'd0);
    chk("r30_idx", 32'(gnt_idx), 32'd0);
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 7) == 0), 3'($urandom));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
